// File: rtl/mips_pkg.sv
// mips_pkg: shared constants and loader state encoding.
package mips_pkg;
    localparam int IMEM_DEPTH = 32;
    localparam int WORD_BYTES = 4;
    typedef enum logic [2:0] {IDLE, HDR, DATA, WRITE, CHK, DONE, ERR} state_t;
endpackage

// File: rtl/imem_word_packer.sv
// imem_word_packer: shifts bytes MSB-first into a 32-bit word, flags each completed word.
module imem_word_packer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        shift,
    input  logic [7:0]  din,
    output logic [31:0] word,
    output logic        last,
    output logic        word_ready
);
    logic [1:0] cnt;
    assign last = cnt == 2'd3;
    // clr leaves the word alone so the last written data stays visible
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word       <= '0;
            cnt        <= '0;
            word_ready <= 1'b0;
        end else if (clr) begin
            cnt        <= '0;
            word_ready <= 1'b0;
        end else begin
            word_ready <= shift && last;
            if (shift) begin
                word <= {word[23:0], din};
                cnt  <= cnt + 2'd1;
            end
        end
    end
endmodule

// File: rtl/imem_loader.sv
// imem_loader: loads a COUNT/data/CHK byte frame into instruction memory as big-endian words,
// holding the CPU until the XOR checksum verifies.
module imem_loader
    import mips_pkg::*;
#(
    parameter int DEPTH = IMEM_DEPTH,
    parameter int AW    = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [7:0]    in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [31:0]   wr_data,
    output logic          cpu_hold,
    output logic          done,
    output logic          err
);
    localparam int IW = $clog2(DEPTH + 1);
    state_t state, nxt;
    logic [IW-1:0] idx, n;
    logic [7:0] chk;
    logic xfer, arm, shift, last, word_ready;
    assign xfer  = in_valid && in_ready;
    assign arm   = start && (state == IDLE || state == DONE || state == ERR);
    assign shift = xfer && state == DATA;
    imem_word_packer u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (arm),
        .shift      (shift),
        .din        (in_data),
        .word       (wr_data),
        .last       (last),
        .word_ready (word_ready)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nxt;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx     <= '0;
            n       <= '0;
            chk     <= '0;
            wr_addr <= '0;
        end else begin
            if (arm) begin
                idx <= '0;
                chk <= '0;
            end
            if (state == HDR && xfer) n <= IW'(in_data);
            // address is captured with the 4th byte so it holds after idx advances
            if (shift) begin
                chk <= chk ^ in_data;
                if (last) wr_addr <= AW'(idx) * AW'(WORD_BYTES);
            end
            if (state == WRITE) idx <= idx + IW'(1);
        end
    end
    always_comb begin
        nxt = state;
        case (state)
            IDLE, DONE, ERR: if (start) nxt = HDR;
            HDR:   if (in_valid) nxt = (in_data == 8'd0 || int'(in_data) > DEPTH) ? ERR : DATA;
            DATA:  if (in_valid && last) nxt = WRITE;
            WRITE: nxt = (idx + IW'(1) == n) ? CHK : DATA;
            CHK:   if (in_valid) nxt = (in_data == chk) ? DONE : ERR;
            default: nxt = IDLE;
        endcase
    end
    always_comb begin
        in_ready = state == HDR || state == DATA || state == CHK;
        wr_en    = state == WRITE && word_ready;
        cpu_hold = state != DONE;
        done     = state == DONE;
        err      = state == ERR;
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed frames with hand-computed writes, checksums and status.
module tb_imem_loader;
    logic        clk = 0, rst_n = 0, start = 0, in_valid = 0;
    logic [7:0]  in_data = 0;
    logic        in_ready, wr_en, cpu_hold, done, err;
    logic [31:0] wr_addr, wr_data;
    int vec = 0, miss = 0, rdy_bad = 0;
    logic [31:0] wa[$], wd[$];
    imem_loader dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .cpu_hold(cpu_hold), .done(done), .err(err)
    );
    always #5 clk = ~clk;
    always @(negedge clk) if (wr_en) begin
        wa.push_back(wr_addr);
        wd.push_back(wr_data);
        if (in_ready) rdy_bad++;
    end
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask
    task automatic send(input logic [7:0] b);
        in_data = b;
        in_valid = 1;
        for (int k = 0; k < 100 && !in_ready; k++) @(negedge clk);
        if (!in_ready) begin
            miss++;
            $display("FAIL send_timeout: observed in_ready=0 expected in_ready=1 for byte %h", b);
        end else begin
            @(posedge clk);
            #1;
        end
        in_valid = 0;
    endtask
    task automatic sendg(input logic [7:0] b);
        repeat ($urandom_range(0, 2)) @(negedge clk);
        send(b);
    endtask
    task automatic pulse_start();
        @(negedge clk);
        start = 1;
        @(posedge clk);
        #1;
        start = 0;
        wa.delete();
        wd.delete();
    endtask
    task automatic check_reset(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready), 0);
        check({tag, "_wr_en"}, 32'(wr_en), 0);
        check({tag, "_wr_addr"}, wr_addr, 0);
        check({tag, "_wr_data"}, wr_data, 0);
        check({tag, "_cpu_hold"}, 32'(cpu_hold), 1);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_err"}, 32'(err), 0);
    endtask
    initial begin
        logic [31:0] w;
        logic [7:0]  c;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset("rst");
        rst_n = 1;
        // N=2 basic image
        pulse_start();
        send(8'd2);
        send(8'h20); send(8'h08); send(8'h00); send(8'h05);
        send(8'h00); send(8'h00); send(8'h00); send(8'h00);
        send(8'h2D);
        check("t1_nwr", wa.size(), 2);
        check("t1_a0", wa[0], 32'h0);
        check("t1_d0", wd[0], 32'h20080005);
        check("t1_a1", wa[1], 32'h4);
        check("t1_d1", wd[1], 32'h0);
        check("t1_done", 32'(done), 1);
        check("t1_hold", 32'(cpu_hold), 0);
        check("t1_err", 32'(err), 0);
        check("t1_addr_hold", wr_addr, 32'h4);
        // start in DONE re-arms
        pulse_start();
        check("rearm_done", 32'(done), 0);
        check("rearm_hold", 32'(cpu_hold), 1);
        check("rearm_ready", 32'(in_ready), 1);
        // bad counts
        send(8'd0);
        check("n0_err", 32'(err), 1);
        check("n0_hold", 32'(cpu_hold), 1);
        check("n0_nwr", wa.size(), 0);
        pulse_start();
        send(8'd33);
        check("n33_err", 32'(err), 1);
        check("n33_done", 32'(done), 0);
        check("n33_nwr", wa.size(), 0);
        // bad checksum: true XOR of AA BB CC DD is 0x00
        pulse_start();
        send(8'd1);
        send(8'hAA); send(8'hBB); send(8'hCC); send(8'hDD);
        send(8'h44);
        check("bad_nwr", wa.size(), 1);
        check("bad_a0", wa[0], 32'h0);
        check("bad_d0", wd[0], 32'hAABBCCDD);
        check("bad_err", 32'(err), 1);
        check("bad_done", 32'(done), 0);
        check("bad_hold", 32'(cpu_hold), 1);
        // start in DATA ignored
        pulse_start();
        send(8'd1);
        send(8'h11);
        pulse_start();
        check("ign_ready", 32'(in_ready), 1);
        send(8'h22); send(8'h33); send(8'h44);
        send(8'h44);
        check("ign_nwr", wa.size(), 1);
        check("ign_d0", wd[0], 32'h11223344);
        check("ign_done", 32'(done), 1);
        // full image with random bubbles
        pulse_start();
        rdy_bad = 0;
        c = 0;
        sendg(8'd32);
        for (int i = 0; i < 32; i++) begin
            w = {8'(i), 8'(i * 3), 8'hA5, ~8'(i)};
            c = c ^ w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
            sendg(w[31:24]); sendg(w[23:16]); sendg(w[15:8]); sendg(w[7:0]);
        end
        sendg(c);
        check("full_nwr", wa.size(), 32);
        for (int i = 0; i < 32 && i < wa.size(); i++) begin
            check($sformatf("full_a%0d", i), wa[i], 32'(i * 4));
            check($sformatf("full_d%0d", i), wd[i], {8'(i), 8'(i * 3), 8'hA5, ~8'(i)});
        end
        check("full_rdy_in_write", rdy_bad, 0);
        check("full_done", 32'(done), 1);
        check("full_err", 32'(err), 0);
        // async reset mid-load
        pulse_start();
        send(8'd2);
        send(8'h01); send(8'h02); send(8'h03); send(8'h04);
        send(8'h05); send(8'h06);
        check("mid_d0", wd[0], 32'h01020304);
        #2;
        rst_n = 0;
        #1;
        check_reset("arst");
        @(negedge clk);
        rst_n = 1;
        pulse_start();
        send(8'd1);
        send(8'h12); send(8'h34); send(8'h56); send(8'h78);
        send(8'h08);
        check("post_nwr", wa.size(), 1);
        check("post_a0", wa[0], 32'h0);
        check("post_d0", wd[0], 32'h12345678);
        check("post_done", 32'(done), 1);
        check("post_hold", 32'(cpu_hold), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end
endmodule
